fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch controller that owns the program counter of the single-cycle core. It generates the sequential next PC (PC + 4), accepts taken-branch/jump redirects, issues requests to instruction memory over a request/acknowledge handshake, and hands fetched words to decode over a valid/ready handshake. It also supports a halt that drains the in-flight fetch, and keeps a count of delivered instructions.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset rst, synchronous, active-high; clock clk
- imem_req  out  1  instruction memory request, held until imem_ack
- imem_addr  out  32  fetch address, stable while imem_req=1
- imem_ack  in  1  memory accepted request; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- inst_valid  out  1  inst/inst_pc hold a deliverable instruction
- inst  out  32  instruction word
- inst_pc  out  32  address of inst
- inst_ready  in  1  decode accepts inst this cycle
- redirect  in  1  taken branch/jump; single-cycle pulse
- redirect_pc  in  32  redirect target
- halt  in  1  request stop after current fetch completes
- halted  out  1  sequencer stopped
- misalign  out  1  one-cycle pulse: redirect_pc[1:0] != 0 was accepted
- fetch_count  out  32  number of completed inst transfers

## Operation
- States: IDLE, REQ, HOLD, HALTED. Internal: pc (32), squash (1), halt_pend (1).
- IDLE: entered on reset; next cycle -> REQ with pc = RESET_PC.
- REQ: imem_req=1, imem_addr=pc. On imem_ack: if squash, discard imem_rdata, clear squash, stay REQ with already-updated pc; else latch inst=imem_rdata, inst_pc=pc, pc<=pc+4, -> HOLD.
- HOLD: inst_valid=1; inst/inst_pc stable. Transfer = inst_valid & inst_ready; on transfer fetch_count+1, -> REQ (or HALTED if halt_pend).
- Redirect (any state except HALTED): target = {redirect_pc[31:2],2'b00}; misalign pulses next cycle if redirect_pc[1:0]!=0.
  - REQ without ack: pc<=target, squash<=1 (address in flight must still complete; imem_addr not changed mid-request).
  - REQ with ack same cycle: data discarded, pc<=target, stay REQ, squash stays 0.
  - HOLD without transfer: instruction dropped, inst_valid<=0, pc<=target, -> REQ.
  - HOLD with transfer same cycle: transfer counts, pc<=target, -> REQ.
  - IDLE: target overrides RESET_PC.
- halt: sets halt_pend (sticky). REQ completes its ack (squashed or not) then -> HALTED if not squash-refetch needed; squashed data never delivered. HOLD waits for transfer, then -> HALTED. Redirect after halt_pend is still honoured on the pending instruction only as drop. HALTED: halted=1, all requests/valid low; exit only via rst.
- Arithmetic: pc+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). fetch_count wraps at 2^32.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, halted=0, misalign=0, fetch_count=0; state IDLE, squash=0, halt_pend=0.
- All outputs registered; no combinational path from inputs to outputs.
- rst high mid-request: request abandoned immediately (imem_req=0 next cycle); memory must tolerate dropped request.
- First imem_req: second cycle after rst deasserts.
- Zero-wait memory (ack in first REQ cycle) and ready decode: one instruction per 2 cycles.
- Redirect to first request of target: 1 cycle (from HOLD) or ack cycle + 1 (from REQ).
- misalign: exactly one cycle, the cycle after redirect sampled.

## Test plan
- Reset, ack always 1, ready always 1, RESET_PC=0x100 -> inst_pc sequence 0x100,0x104,0x108; inst_valid every other cycle; fetch_count=3 after third transfer.
- ack delayed 3 cycles -> imem_addr stays 0x104 for all 4 REQ cycles; inst_pc=0x104, inst=imem_rdata from ack cycle.
- Redirect to 0x200 while REQ for 0x108 awaiting ack -> data at 0x108 never valid; next imem_addr=0x200; fetch_count unchanged by 0x108.
- Redirect to 0x203 in HOLD with inst_ready=0 -> held instruction dropped, misalign=1 for one cycle, next inst_pc=0x200.
- halt during HOLD with ready=0 for 2 cycles -> transfer on ready, then halted=1, imem_req stays 0 for 10 cycles; redirect ignored.
- pc=0xFFFF_FFFC fetch -> next imem_addr=0x0000_0000; rst asserted mid-REQ -> imem_req=0 and imem_addr=RESET_PC next cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches over a req/ack handshake to imem,
// and presents each fetched word to decode over valid/ready. Supports redirect and halt.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted,
    output logic        misalign,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, HALTED} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        squash;
    logic        halt_pend;

    logic [31:0] target;
    logic [31:0] next_pc;
    logic        halt_now;
    logic        xfer;

    assign target   = {redirect_pc[31:2], 2'b00};
    assign next_pc  = redirect ? target : pc;
    assign halt_now = halt | halt_pend;
    assign xfer     = inst_valid & inst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            squash      <= 1'b0;
            halt_pend   <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            inst_valid  <= 1'b0;
            inst        <= '0;
            inst_pc     <= '0;
            halted      <= 1'b0;
            misalign    <= 1'b0;
            fetch_count <= '0;
        end else begin
            misalign <= 1'b0;
            if (state != HALTED) begin
                if (halt) halt_pend <= 1'b1;
                misalign <= redirect && (redirect_pc[1:0] != 2'b00);
            end

            case (state)
                IDLE: begin
                    pc        <= redirect ? target : RESET_PC;
                    imem_addr <= redirect ? target : RESET_PC;
                    imem_req  <= 1'b1;
                    state     <= REQ;
                end

                REQ: begin
                    if (imem_ack) begin
                        if (squash || redirect) begin
                            // Stale data: drop it and either refetch from the new pc or stop.
                            squash <= 1'b0;
                            if (halt_now) begin
                                imem_req <= 1'b0;
                                halted   <= 1'b1;
                                state    <= HALTED;
                            end else begin
                                pc        <= next_pc;
                                imem_addr <= next_pc;
                            end
                        end else begin
                            inst       <= imem_rdata;
                            inst_pc    <= imem_addr;
                            pc         <= imem_addr + 32'd4;
                            inst_valid <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= HOLD;
                        end
                    end else if (redirect) begin
                        // The in-flight address must finish; remember to discard its data.
                        pc     <= target;
                        squash <= 1'b1;
                    end
                end

                HOLD: begin
                    if (xfer) fetch_count <= fetch_count + 32'd1;
                    if (xfer || redirect) begin
                        inst_valid <= 1'b0;
                        pc         <= next_pc;
                        if (halt_now) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= next_pc;
                            state     <= REQ;
                        end
                    end
                end

                HALTED: ;

                default: state <= IDLE;
            endcase
        end
    end

endmodule
